// File: rtl/riscv_pkg.sv
// Types and constants shared by the fetch unit and the instruction decoder.
package riscv_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {instr, pc} entries with a
// zero-latency head read and a flush that beats push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  fetch_entry_t                i_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output fetch_entry_t                o_head,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  fetch_entry_t r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_full;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (o_count == '0);
  assign w_full    = (o_count == (AW + 1)'(FIFO_DEPTH));
  assign w_do_push = i_push & ~w_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues word reads, buffers responses with their PCs.
// Define IFETCH_MISALIGN_TRAP_EN to trap misaligned redirects into HALT.
module instruction_fetch #(
  parameter int unsigned     XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            im_req_valid,
  input  logic            im_req_ready,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_rsp_valid,
  input  logic [XLEN-1:0] im_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instruction_valid,
  input  logic            instruction_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instruction_pc,
  output logic            fetch_misaligned
);
  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 4;

  fetch_state_t               r_state, w_state_next;
  logic [XLEN-1:0]            r_fetch_pc, r_rsp_pc;
  logic [CW-1:0]              r_inflight, r_drop, w_inflight_next, w_occupied;
  logic                       r_misaligned;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                       w_fifo_empty, w_credit, w_req_fire, w_rsp_take;
  logic                       w_push, w_pop, w_redirect_bad;
  logic [XLEN-1:0]            w_redirect_target;
  fetch_entry_t               w_push_entry, w_head;

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign w_redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect_bad = 1'b0;
`endif
  assign w_redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

  assign w_occupied      = CW'(w_fifo_count) + r_inflight - r_drop;
  assign w_credit        = (w_occupied < CW'(FIFO_DEPTH));
  assign im_req_valid    = ~reset & (r_state == FETCH) & ~redirect_valid & w_credit;
  assign im_addr         = r_fetch_pc;
  assign w_req_fire      = im_req_valid & im_req_ready;
  assign w_rsp_take      = im_rsp_valid & (r_inflight != '0);
  assign w_inflight_next = r_inflight + CW'(w_req_fire) - CW'(w_rsp_take);
  assign w_push          = w_rsp_take & (r_drop == '0) & ~redirect_valid & (r_state == FETCH);
  assign w_pop           = instruction_valid & instruction_ready & ~redirect_valid;
  assign w_push_entry    = '{instr: im_rsp_data, pc: r_rsp_pc};

  assign instruction_valid = ~w_fifo_empty;
  assign instruction       = w_head.instr;
  assign instruction_pc    = w_head.pc;
  assign fetch_misaligned  = r_misaligned;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) w_state_next = w_redirect_bad ? HALT : FETCH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_rsp_pc     <= RESET_PC;
      r_inflight   <= '0;
      r_drop       <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_inflight   <= w_inflight_next;
      r_misaligned <= w_redirect_bad;
      if (redirect_valid) begin
        // Every request still outstanding after this cycle is stale, including
        // ones already marked, so the drop count is the whole remaining inflight.
        r_drop <= w_inflight_next;
        if (!w_redirect_bad) begin
          r_fetch_pc <= w_redirect_target;
          r_rsp_pc   <= w_redirect_target;
        end
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_rsp_take && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) r_rsp_pc <= r_rsp_pc + XLEN'(4);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a latency-configurable memory model
// and a scoreboard of accepted request addresses.
module tb_instruction_fetch;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        im_req_valid, im_req_ready;
  logic [31:0] im_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instruction_valid, instruction_ready;
  logic [31:0] instruction, instruction_pc;
  logic        fetch_misaligned;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cyc = 0;
  int unsigned mem_lat = 1;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] sb[$];

  initial forever #5 clk = ~clk;

  instruction_fetch #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .im_req_valid      (im_req_valid),
    .im_req_ready      (im_req_ready),
    .im_addr           (im_addr),
    .im_rsp_valid      (im_rsp_valid),
    .im_rsp_data       (im_rsp_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .fetch_misaligned  (fetch_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_next(input logic [31:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      at_neg();
      if (!reset && !redirect_valid && instruction_valid && instruction_ready) begin
        seen = 1'b1;
        chk($sformatf("next_pc_%h", pc), instruction_pc, pc);
        chk($sformatf("next_data_%h", pc), instruction, pc ^ MASK);
      end
    end
    chk($sformatf("next_seen_%h", pc), 32'(seen), 32'd1);
  endtask

  // Scoreboard: accepted requests are pushed, consumed instructions popped.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb.delete();
      mq.delete();
    end else begin
      if (redirect_valid) begin
        sb.delete();
      end else if (instruction_valid && instruction_ready) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_errors++;
          $error("FAIL sb_empty: observed pc %h expected no delivery", instruction_pc);
        end
        if (sb.size() != 0) begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("sb_pc", instruction_pc, e);
          chk("sb_data", instruction, e ^ MASK);
        end
      end
      if (im_req_valid && im_req_ready) begin
        sb.push_back(im_addr);
        mq.push_back('{addr: im_addr, due: cyc + mem_lat});
      end
    end
  end

  // Memory: in-order responses, mem_lat cycles after acceptance.
  initial begin
    im_rsp_valid = 1'b0;
    im_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        im_rsp_valid = 1'b1;
        im_rsp_data  = mq[0].addr ^ MASK;
        void'(mq.pop_front());
      end else begin
        im_rsp_valid = 1'b0;
        im_rsp_data  = $urandom;
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset             = 1'b1;
    im_req_ready      = 1'b1;
    instruction_ready = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;

    // Reset state and first-fetch latency
    tick(2);
    at_neg();
    chk("rst_req_valid", 32'(im_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instruction_valid), 32'd0);
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    tick(1);
    reset = 1'b0;
    at_neg();
    chk("t1_req_valid", 32'(im_req_valid), 32'd1);
    chk("t1_addr", im_addr, 32'h0);
    chk("t1_valid_c0", 32'(instruction_valid), 32'd0);
    at_neg();
    chk("t1_valid_c1", 32'(instruction_valid), 32'd0);
    at_neg();
    chk("t1_valid_c2", 32'(instruction_valid), 32'd1);
    chk("t1_pc0", instruction_pc, 32'h0);
    chk("t1_data0", instruction, 32'hA5A5_0000);
    expect_next(32'h4);
    expect_next(32'h8);
    expect_next(32'hC);

    // Decoder stall: buffer fills to depth, issue stops
    tick(1);
    instruction_ready = 1'b0;
    tick(10);
    at_neg();
    chk("t2_req_valid", 32'(im_req_valid), 32'd0);
    chk("t2_instr_valid", 32'(instruction_valid), 32'd1);
    chk("t2_head_pc", instruction_pc, 32'h10);
    chk("t2_buffered", 32'(sb.size()), 32'd2);
    tick(1);
    instruction_ready = 1'b1;
    expect_next(32'h10);
    expect_next(32'h14);
    expect_next(32'h18);

    // Redirect with two requests in flight
    mem_lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_neg();
      if (mq.size() == 2) found = 1'b1;
    end
    chk("t3_two_inflight", 32'(found), 32'd1);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    at_neg();
    chk("t3_req_blocked", 32'(im_req_valid), 32'd0);
    chk("t3_stale_rsp0", 32'(im_rsp_valid), 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    at_neg();
    chk("t3_stale_rsp1", 32'(im_rsp_valid), 32'd1);
    chk("t3_flushed", 32'(instruction_valid), 32'd0);
    expect_next(32'h100);
    expect_next(32'h104);
    mem_lat = 1;

    // Redirect coinciding with a response and a pop
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_neg();
      if (im_req_valid && im_req_ready && im_rsp_valid) found = 1'b1;
    end
    chk("t4_setup", 32'(found), 32'd1);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    at_neg();
    chk("t4_pop_pending", 32'(instruction_valid), 32'd1);
    chk("t4_rsp_same", 32'(im_rsp_valid), 32'd1);
    chk("t4_req_blocked", 32'(im_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    at_neg();
    chk("t4_empty", 32'(instruction_valid), 32'd0);
    expect_next(32'h300);
    expect_next(32'h304);

    // Memory back-pressure: address held while not accepted
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    im_req_ready   = 1'b0;
    at_neg();
    chk("t5_redirect_no_req", 32'(im_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("t5_hold_valid_%0d", i), 32'(im_req_valid), 32'd1);
      chk($sformatf("t5_hold_addr_%0d", i), im_addr, 32'h400);
    end
    tick(1);
    im_req_ready = 1'b1;
    expect_next(32'h400);
    expect_next(32'h404);

    // Misaligned redirect
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick(1);
    redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    at_neg();
    chk("t6_mis_pulse", 32'(fetch_misaligned), 32'd1);
    chk("t6_halt_req0", 32'(im_req_valid), 32'd0);
    at_neg();
    chk("t6_mis_clear", 32'(fetch_misaligned), 32'd0);
    chk("t6_halt_req1", 32'(im_req_valid), 32'd0);
    chk("t6_halt_empty", 32'(instruction_valid), 32'd0);
    tick(3);
    at_neg();
    chk("t6_halt_req2", 32'(im_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick(1);
    redirect_valid = 1'b0;
    expect_next(32'h200);
    expect_next(32'h204);
`else
    at_neg();
    chk("t6_mis_tied", 32'(fetch_misaligned), 32'd0);
    expect_next(32'h100);
    expect_next(32'h104);
`endif

    // Reset mid-operation beats a simultaneous redirect
    tick(1);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    at_neg();
    chk("t7_rst_req", 32'(im_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    at_neg();
    chk("t7_rst_valid", 32'(instruction_valid), 32'd0);
    chk("t7_rst_mis", 32'(fetch_misaligned), 32'd0);
    tick(1);
    reset = 1'b0;
    expect_next(32'h0);
    expect_next(32'h4);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
